// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM word-line drivers.
// Contents: default array geometry, the driver FSM state type, and the
// precision clamp used when a vector is accepted.
package dcim_pkg;

  localparam int unsigned ACT_BITS_DEF = 8;
  localparam int unsigned NUM_IN_DEF   = 8;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // A requested precision of 0, or one above the datapath maximum, means "full precision".
  function automatic logic [3:0] clamp_prec(input logic [3:0] prec, input logic [3:0] max_prec);
    return ((prec == 4'd0) || (prec > max_prec)) ? max_prec : prec;
  endfunction

endpackage

// File: rtl/rwlb_plane_sel.sv
// Bit-plane selector for the read-word-line bus.
// Picks bit[plane_idx] of every lane in both rows and drives it active-low.
// When en=0 every line is held at 1 (idle, no word line asserted).
// Ports:
//   act_row0/act_row1  in   NUM_IN*ACT_BITS  packed lanes, lane i = [i*ACT_BITS +: ACT_BITS]
//   plane_idx          in   IDX_W            bit position to select
//   en                 in   1                a plane is being presented
//   rwlb_row0/row1     out  NUM_IN           active-low word lines
module rwlb_plane_sel #(
  parameter int unsigned ACT_BITS = 8,
  parameter int unsigned NUM_IN   = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [NUM_IN*ACT_BITS-1:0] act_row0,
  input  logic [NUM_IN*ACT_BITS-1:0] act_row1,
  input  logic [IDX_W-1:0]           plane_idx,
  input  logic                       en,
  output logic [NUM_IN-1:0]          rwlb_row0,
  output logic [NUM_IN-1:0]          rwlb_row1
);

  logic [ACT_BITS-1:0] lane0;
  logic [ACT_BITS-1:0] lane1;

  always_comb begin
    rwlb_row0 = '1;
    rwlb_row1 = '1;
    lane0     = '0;
    lane1     = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      lane0        = act_row0[i*ACT_BITS +: ACT_BITS];
      lane1        = act_row1[i*ACT_BITS +: ACT_BITS];
      rwlb_row0[i] = en ? ~lane0[plane_idx] : 1'b1;
      rwlb_row1[i] = en ? ~lane1[plane_idx] : 1'b1;
    end
  end

endmodule

// File: rtl/rwlb_bitplane_driver.sv
// Transmit side of the local MAC word-line interface.
// Accepts one 2-row activation vector per transaction and serialises it LSB-first into
// active-low bit-planes with sus/plane framing for the downstream shift-accumulator.
// Optional feature macro RWLB_DOUBLE_BUF_EN: adds a shadow vector register so the next
// vector is accepted while streaming and planes run back-to-back with no idle cycle.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      vector handshake
//   act_row0/act_row1      packed activations, lane i = [i*ACT_BITS +: ACT_BITS]
//   in_sus                 1 = two's-complement (MSB plane is the sign plane)
//   in_prec                planes to emit, 0 or >ACT_BITS means ACT_BITS
//   plane_valid/ready      plane handshake
//   rwlb_row0/rwlb_row1    active-low word lines, all 1s when no plane is valid
//   sus, plane_idx         framing of the current plane
//   plane_first/last       plane_idx==0 / plane_idx==prec-1
module rwlb_bitplane_driver
  import dcim_pkg::*;
#(
  parameter int unsigned ACT_BITS = ACT_BITS_DEF,
  parameter int unsigned NUM_IN   = NUM_IN_DEF,
  parameter int unsigned IDX_W    = $clog2(ACT_BITS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_IN*ACT_BITS-1:0] act_row0,
  input  logic [NUM_IN*ACT_BITS-1:0] act_row1,
  input  logic                       in_sus,
  input  logic [3:0]                 in_prec,
  input  logic                       plane_ready,
  output logic                       plane_valid,
  output logic [NUM_IN-1:0]          rwlb_row0,
  output logic [NUM_IN-1:0]          rwlb_row1,
  output logic                       sus,
  output logic [IDX_W-1:0]           plane_idx,
  output logic                       plane_first,
  output logic                       plane_last
);

  localparam int unsigned VecW = NUM_IN * ACT_BITS;

  state_e            state_q;
  logic [VecW-1:0]   act0_q, act1_q;
  logic              sus_q;
  logic [3:0]        prec_q;
  logic [IDX_W-1:0]  idx_q;
  logic              rdy_en_q;  // keeps in_ready low through reset and for the release edge

  logic              accept;
  logic              plane_fire;
  logic [3:0]        prec_clamped;

`ifdef RWLB_DOUBLE_BUF_EN
  logic [VecW-1:0]   shd0_q, shd1_q;
  logic              shd_sus_q;
  logic [3:0]        shd_prec_q;
  logic              shd_valid_q;

  assign in_ready = rdy_en_q & ~shd_valid_q;
`else
  assign in_ready = rdy_en_q & (state_q == IDLE);
`endif

  assign accept       = in_valid & in_ready;
  assign plane_valid  = (state_q == STREAM);
  assign plane_fire   = plane_valid & plane_ready;
  assign prec_clamped = clamp_prec(in_prec, 4'(ACT_BITS));

  assign sus          = sus_q;
  assign plane_idx    = idx_q;
  assign plane_first  = plane_valid & (idx_q == '0);
  assign plane_last   = plane_valid & (4'(idx_q) == (prec_q - 4'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      act0_q   <= '0;
      act1_q   <= '0;
      sus_q    <= 1'b0;
      prec_q   <= '0;
      idx_q    <= '0;
      rdy_en_q <= 1'b0;
`ifdef RWLB_DOUBLE_BUF_EN
      shd0_q      <= '0;
      shd1_q      <= '0;
      shd_sus_q   <= 1'b0;
      shd_prec_q  <= '0;
      shd_valid_q <= 1'b0;
`endif
    end else begin
      rdy_en_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            act0_q  <= act_row0;
            act1_q  <= act_row1;
            sus_q   <= in_sus;
            prec_q  <= prec_clamped;
            idx_q   <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (plane_fire) begin
            if (plane_last) begin
              idx_q <= '0;
`ifdef RWLB_DOUBLE_BUF_EN
              // Shadow is empty whenever accept is high, so the incoming vector bypasses it.
              if (accept) begin
                act0_q <= act_row0;
                act1_q <= act_row1;
                sus_q  <= in_sus;
                prec_q <= prec_clamped;
              end else if (shd_valid_q) begin
                act0_q      <= shd0_q;
                act1_q      <= shd1_q;
                sus_q       <= shd_sus_q;
                prec_q      <= shd_prec_q;
                shd_valid_q <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
`else
              state_q <= IDLE;
`endif
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
`ifdef RWLB_DOUBLE_BUF_EN
          if (accept && !(plane_fire && plane_last)) begin
            shd0_q      <= act_row0;
            shd1_q      <= act_row1;
            shd_sus_q   <= in_sus;
            shd_prec_q  <= prec_clamped;
            shd_valid_q <= 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rwlb_plane_sel #(
    .ACT_BITS (ACT_BITS),
    .NUM_IN   (NUM_IN),
    .IDX_W    (IDX_W)
  ) u_plane_sel (
    .act_row0  (act0_q),
    .act_row1  (act1_q),
    .plane_idx (idx_q),
    .en        (plane_valid),
    .rwlb_row0 (rwlb_row0),
    .rwlb_row1 (rwlb_row1)
  );

endmodule

// File: tb/tb_rwlb_bitplane_driver.sv
// Self-checking bench for rwlb_bitplane_driver (default geometry 8 lanes x 8 bits).
// A queue-based model expands every accepted vector into its expected planes; a compare
// process checks each handshaked plane and the idle word-line level. Directed checks pin
// reset, the first plane, sign framing, stalls, mid-stream reset and stream spacing.
module tb_rwlb_bitplane_driver;

  localparam int AB = 8;
  localparam int NI = 8;
`ifdef RWLB_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   act_row0;
  logic [63:0]   act_row1;
  logic          in_sus;
  logic [3:0]    in_prec;
  logic          plane_ready;
  logic          plane_valid;
  logic [7:0]    rwlb_row0;
  logic [7:0]    rwlb_row1;
  logic          sus;
  logic [2:0]    plane_idx;
  logic          plane_first;
  logic          plane_last;

  always #5 clk = ~clk;

  rwlb_bitplane_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .act_row0    (act_row0),
    .act_row1    (act_row1),
    .in_sus      (in_sus),
    .in_prec     (in_prec),
    .plane_ready (plane_ready),
    .plane_valid (plane_valid),
    .rwlb_row0   (rwlb_row0),
    .rwlb_row1   (rwlb_row1),
    .sus         (sus),
    .plane_idx   (plane_idx),
    .plane_first (plane_first),
    .plane_last  (plane_last)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] r0;
    logic [7:0] r1;
    logic       s;
    int         idx;
    logic       first;
    logic       last;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Expand a vector into its planes: plane k carries bit k of each lane, inverted.
  function automatic void push_vector(input logic [63:0] r0, input logic [63:0] r1,
                                      input logic s, input logic [3:0] p);
    int n;
    exp_t e;
    n = (p == 0 || p > AB) ? AB : int'(p);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NI; i++) begin
        e.r0[i] = ~r0[i*AB+k];
        e.r1[i] = ~r1[i*AB+k];
      end
      e.s     = s;
      e.idx   = k;
      e.first = (k == 0);
      e.last  = (k == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin : compare
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (plane_valid && plane_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_extra_plane: got plane idx %0d expected none at %0t", plane_idx, $time);
        end else begin
          e = exp_q.pop_front();
          chk("m_row0", rwlb_row0, e.r0);
          chk("m_row1", rwlb_row1, e.r1);
          chk("m_sus", sus, e.s);
          chk("m_idx", plane_idx, e.idx);
          chk("m_first", plane_first, e.first);
          chk("m_last", plane_last, e.last);
        end
      end else if (!plane_valid) begin
        chk("m_idle_row0", rwlb_row0, 8'hFF);
        chk("m_idle_row1", rwlb_row1, 8'hFF);
      end
      if (in_valid && in_ready) push_vector(act_row0, act_row1, in_sus, in_prec);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic offer(input logic [63:0] r0, input logic [63:0] r1, input logic s,
                       input logic [3:0] p);
    int n;
    n        = 0;
    in_valid = 1'b1;
    act_row0 = r0;
    act_row1 = r1;
    in_sus   = s;
    in_prec  = p;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("offer_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready && !plane_valid) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (n >= 60) fail_now("wait_idle");
    @(posedge clk);
    #1;
  endtask

  logic [63:0] va, vb;
  logic [3:0]  t3_seq;
  logic [19:0] got_pat, exp_pat;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    act_row0    = '0;
    act_row1    = '0;
    in_sus      = 1'b0;
    in_prec     = '0;
    plane_ready = 1'b1;

    // Reset held for 3 edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row0", rwlb_row0, 8'hFF);
    chk("rst_row1", rwlb_row1, 8'hFF);
    chk("rst_valid", plane_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_idx", plane_idx, 3'd0);
    chk("rst_sus", sus, 1'b0);
    chk("rst_first", plane_first, 1'b0);
    chk("rst_last", plane_last, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    chk("rel_ready_after_edge", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Unsigned, full precision
    offer({8{8'h01}}, {8{8'h80}}, 1'b0, 4'd8);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("t2_p0_valid", plane_valid, 1'b1);
        chk("t2_p0_row0", rwlb_row0, 8'h00);
        chk("t2_p0_row1", rwlb_row1, 8'hFF);
        chk("t2_p0_first", plane_first, 1'b1);
        chk("t2_busy_ready", in_ready, DBL);
      end
      if (k == 7) begin
        chk("t2_p7_row0", rwlb_row0, 8'hFF);
        chk("t2_p7_row1", rwlb_row1, 8'h00);
        chk("t2_p7_last", plane_last, 1'b1);
        chk("t2_p7_sus", sus, 1'b0);
        chk("t2_p7_idx", plane_idx, 3'd7);
      end
      if (k == 8) begin
        chk("t2_ready_back", in_ready, 1'b1);
        chk("t2_valid_drop", plane_valid, 1'b0);
      end
      @(posedge clk);
      #1;
    end

    // Signed, prec=4: lane0 = 4'b1010
    t3_seq = 4'b0101;
    offer(64'h0A, 64'h0, 1'b1, 4'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_lane0", rwlb_row0[0], t3_seq[k]);
      chk("t3_other_lanes", rwlb_row0[7:1], 7'h7F);
      chk("t3_sus", sus, 1'b1);
      chk("t3_last", plane_last, (k == 3));
      @(posedge clk);
      #1;
    end
    wait_idle();

    // prec=1: single plane is both first and last
    offer(64'h01, 64'h0, 1'b0, 4'd1);
    chk("t_p1_first", plane_first, 1'b1);
    chk("t_p1_last", plane_last, 1'b1);
    chk("t_p1_row0", rwlb_row0, 8'hFE);
    @(posedge clk);
    #1;
    chk("t_p1_done", plane_valid, 1'b0);
    wait_idle();

    // Stall at plane 2, prec=0 clamps to 8. Row0 lane i = i, row1 lane i = ~i.
    for (int i = 0; i < NI; i++) begin
      va[i*AB +: AB] = 8'(i);
      vb[i*AB +: AB] = 8'hFF ^ 8'(i);
    end
    offer(va, vb, 1'b0, 4'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    plane_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_stall_valid", plane_valid, 1'b1);
      chk("t4_stall_idx", plane_idx, 3'd2);
      chk("t4_stall_row0", rwlb_row0, 8'h0F);
      chk("t4_stall_row1", rwlb_row1, 8'hF0);
      @(posedge clk);
      #1;
    end
    plane_ready = 1'b1;
    wait_idle();

    // Reset while plane 3 is on the lines
    offer(va, vb, 1'b1, 4'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_pre_idx", plane_idx, 3'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst_valid", plane_valid, 1'b0);
    chk("t5_rst_row0", rwlb_row0, 8'hFF);
    chk("t5_rst_row1", rwlb_row1, 8'hFF);
    chk("t5_rst_idx", plane_idx, 3'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    offer(vb, va, 1'b0, 4'd8);
    chk("t5_new_idx", plane_idx, 3'd0);
    chk("t5_new_first", plane_first, 1'b1);
    wait_idle();

    // Two vectors offered back-to-back
    fork
      begin
        offer(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 4'd8);
        offer(64'hA5A5_5A5A_0F0F_F0F0, 64'h1122_3344_5566_7788, 1'b0, 4'd8);
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          got_pat[k] = plane_valid;
        end
      end
    join
    for (int k = 0; k < 20; k++) begin
      if (DBL) exp_pat[k] = (k >= 1 && k <= 16);
      else     exp_pat[k] = (k >= 1 && k <= 8) || (k >= 10 && k <= 17);
    end
    chk("t6_valid_pattern", got_pat, exp_pat);
    @(posedge clk);
    #1;
    wait_idle();

    chk("leftover_planes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

endmodule
